fetch_pc: RTL and testbench

Program-counter register and instruction-fetch sequencer for the RV32 core. It holds the architectural PC and issues one word fetch at a time to instruction memory. It delivers each fetched instruction with its PC to decode, then advances the PC by 4 or redirects it on branch, trap or mret. It is the consumer of the pc4 incrementer: pc4 produces PC+4, and fetch_pc decides when and whether that value becomes the PC.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/pc4.sv | 17 +
 rtl/fetch_pc.sv | 175 +++++++++++++++++
 tb/tb_fetch_pc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   XLEN    : architectural register / address width
//   NOP     : canonical RV32 no-op (addi x0,x0,0), used as the reset instruction
//   state_t : fetch sequencer states
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      OUT,
      DRAIN,
      HALT
   } state_t;

endpackage

// File: rtl/pc4.sv
// ---------------------------------------------------------------------------
// pc4
// Sequential-PC incrementer: produces PC+4, wrapping modulo 2^XLEN.
//   i_pc  : current program counter
//   o_pc4 : i_pc + 4
// ---------------------------------------------------------------------------
module pc4
   import fetch_pkg::*;
(
   input  logic [XLEN-1:0] i_pc,
   output logic [XLEN-1:0] o_pc4
);

   // Carry out of the top bit is simply dropped, so FFFF_FFFC + 4 wraps to 0.
   assign o_pc4 = i_pc + 32'd4;

endmodule

// File: rtl/fetch_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Issues one word fetch at a time, hands the returned word and its PC to
// decode, then advances by 4 (via pc4) or redirects on trap / mret / branch.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : decode not ready, hold the delivered instruction
//   redirect_valid/pc   : taken branch/jal/jalr and its target
//   trap / trap_vec     : exception or interrupt and its vector
//   mret / mepc         : return from trap and its target
//   imem_req/addr       : fetch request and word address (Moore, state REQ)
//   imem_gnt            : request accepted this cycle
//   imem_rvalid/rdata   : read response
//   inst_valid/inst/pc  : instruction delivered to decode
//   misalign/_pc        : one-cycle pulse with the offending redirect target
// ---------------------------------------------------------------------------
module fetch_pc
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            mret,
   input  logic [XLEN-1:0] mepc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign,
   output logic [XLEN-1:0] misalign_pc
);

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_inst_pc;
   logic            r_misalign;
   logic [XLEN-1:0] r_misalign_pc;
   logic            r_drain_halt;   // DRAIN must exit to HALT (misaligned target)

   state_t          w_state_next;
   logic [XLEN-1:0] w_pc_next;
   logic [XLEN-1:0] w_pc4;
   logic            w_drain_halt_next;
   logic            w_capture;
   logic            w_cf;
   logic            w_chk;
   logic [XLEN-1:0] w_tgt;
   logic            w_tgt_bad;
   logic            w_pending;

   pc4 u_pc4 (
      .i_pc  (r_pc),
      .o_pc4 (w_pc4)
   );

   // Control-flow target selection: trap > mret > redirect. Only the
   // redirect target is checked for alignment; the CSR unit guarantees the
   // others. A redirect cannot pull the sequencer out of HALT.
   always_comb begin
      w_cf  = 1'b0;
      w_chk = 1'b0;
      w_tgt = r_pc;
      if (trap) begin
         w_cf  = 1'b1;
         w_tgt = trap_vec;
      end else if (mret) begin
         w_cf  = 1'b1;
         w_tgt = mepc;
      end else if (redirect_valid && (r_state != HALT)) begin
         w_cf  = 1'b1;
         w_chk = 1'b1;
         w_tgt = redirect_pc;
      end
   end

   assign w_tgt_bad = w_chk && (w_tgt[1:0] != 2'b00);

   // A response is still owed by memory if a grant lands this cycle, or if
   // we are waiting/draining and the response has not arrived yet. A
   // response arriving in the same cycle as the redirect is consumed here.
   assign w_pending = ((r_state == REQ) && imem_gnt) ||
                      (((r_state == WAIT) || (r_state == DRAIN)) && !imem_rvalid);

   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_drain_halt_next = r_drain_halt;
      w_capture         = 1'b0;

      case (r_state)
         IDLE:  w_state_next = REQ;
         REQ: begin
            if (imem_gnt) w_state_next = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_capture    = 1'b1;
               w_state_next = OUT;
            end
         end
         OUT: begin
            if (!stall) begin
               w_pc_next    = w_pc4;
               w_state_next = REQ;
            end
         end
         DRAIN: begin
            if (imem_rvalid) begin
               w_state_next      = r_drain_halt ? HALT : REQ;
               w_drain_halt_next = 1'b0;
            end
         end
         HALT:    w_state_next = HALT;
         default: w_state_next = IDLE;
      endcase

      // Control-flow change overrides stall and the normal sequencing.
      if (w_cf) begin
         w_capture = 1'b0;
         if (w_tgt_bad) begin
            w_pc_next         = r_pc;
            w_state_next      = w_pending ? DRAIN : HALT;
            w_drain_halt_next = w_pending;
         end else begin
            w_pc_next         = w_tgt;
            w_state_next      = w_pending ? DRAIN : REQ;
            w_drain_halt_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_inst        <= NOP;
         r_inst_pc     <= RESET_PC;
         r_misalign    <= 1'b0;
         r_misalign_pc <= '0;
         r_drain_halt  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_drain_halt <= w_drain_halt_next;
         r_misalign   <= w_cf && w_tgt_bad;
         if (w_cf && w_tgt_bad) r_misalign_pc <= w_tgt;
         if (w_capture) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
         end
      end
   end

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = r_pc;
   assign inst_valid  = (r_state == OUT);
   assign inst        = r_inst;
   assign inst_pc     = r_inst_pc;
   assign misalign    = r_misalign;
   assign misalign_pc = r_misalign_pc;

endmodule

// File: tb/tb_fetch_pc.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc
// Directed bench for fetch_pc. Memory model: grant whenever requested,
// read data = address ^ 32'h0050_0093, returned 1 cycle after grant (or 2
// cycles when "slow" is set). A second instance with RESET_PC=FFFF_FFF8
// covers the wrap-around of the sequential increment.
// ---------------------------------------------------------------------------
module tb_fetch_pc;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic        stall, redirect_valid, trap, mret;
   logic [31:0] redirect_pc, trap_vec, mepc;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        inst_valid, misalign;
   logic [31:0] inst, inst_pc, misalign_pc;

   logic        imem_req2, imem_gnt2, imem_rvalid2;
   logic [31:0] imem_addr2, imem_rdata2;
   logic        inst_valid2, misalign2;
   logic [31:0] inst2, inst_pc2, misalign_pc2;
   logic        zero1;
   logic [31:0] zero32;

   logic        slow;
   logic        p1, p2, q1;
   logic [31:0] a1, a2, qa1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_pc u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap(trap), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .misalign(misalign), .misalign_pc(misalign_pc)
   );

   fetch_pc #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .stall(zero1),
      .redirect_valid(zero1), .redirect_pc(zero32),
      .trap(zero1), .trap_vec(zero32), .mret(zero1), .mepc(zero32),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
      .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
      .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
      .misalign(misalign2), .misalign_pc(misalign_pc2)
   );

   // Memory models
   assign imem_gnt    = imem_req;
   assign imem_rvalid = slow ? p2 : p1;
   assign imem_rdata  = (slow ? a2 : a1) ^ 32'h0050_0093;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= 1'b0; p2 <= 1'b0; a1 <= '0; a2 <= '0;
      end else begin
         p1 <= imem_req & imem_gnt;
         a1 <= imem_addr;
         p2 <= p1;
         a2 <= a1;
      end
   end

   assign imem_gnt2    = imem_req2;
   assign imem_rvalid2 = q1;
   assign imem_rdata2  = qa1 ^ 32'h0050_0093;

   always @(posedge clk or negedge rst2_n) begin
      if (!rst2_n) begin
         q1 <= 1'b0; qa1 <= '0;
      end else begin
         q1  <= imem_req2 & imem_gnt2;
         qa1 <= imem_addr2;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-22s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      stall = 1'b0; redirect_valid = 1'b0; trap = 1'b0; mret = 1'b0;
      redirect_pc = '0; trap_vec = '0; mepc = '0;
      zero1 = 1'b0; zero32 = '0; slow = 1'b0;
      nxt(); nxt();

      // Reset state
      chk("rst_req",         {31'd0, imem_req},   32'd0);
      chk("rst_inst_valid",  {31'd0, inst_valid}, 32'd0);
      chk("rst_misalign",    {31'd0, misalign},   32'd0);
      chk("rst_inst",        inst,                32'h0000_0013);
      chk("rst_inst_pc",     inst_pc,             32'h0);
      chk("rst_misalign_pc", misalign_pc,         32'h0);
      chk("rst_addr",        imem_addr,           32'h0);

      // First fetch: REQ, WAIT, OUT
      rst_n = 1'b1;
      nxt();
      chk("f0_req",  {31'd0, imem_req}, 32'd1);
      chk("f0_addr", imem_addr,         32'h0);
      nxt();
      chk("f0_wait_valid", {31'd0, inst_valid}, 32'd0);
      nxt();
      chk("f0_valid",   {31'd0, inst_valid}, 32'd1);
      chk("f0_inst",    inst,                32'h0050_0093);
      chk("f0_inst_pc", inst_pc,             32'h0);
      nxt();
      chk("f1_addr", imem_addr,          32'h4);
      chk("f1_req",  {31'd0, imem_req},  32'd1);

      // Stall held 5 cycles in OUT
      stall = 1'b1;
      nxt(); nxt();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid",   {31'd0, inst_valid}, 32'd1);
         chk("stall_inst",    inst,                32'h0050_0097);
         chk("stall_inst_pc", inst_pc,             32'h4);
         chk("stall_no_req",  {31'd0, imem_req},   32'd0);
         nxt();
      end
      stall = 1'b0;
      nxt();
      chk("post_stall_addr", imem_addr, 32'h8);

      // Redirect during WAIT with a 2-cycle response: response is drained
      slow = 1'b1;
      nxt();
      chk("rd_wait_valid", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      nxt();
      redirect_valid = 1'b0;
      chk("rd_drain_req",   {31'd0, imem_req},   32'd0);
      chk("rd_drain_valid", {31'd0, inst_valid}, 32'd0);
      nxt();
      chk("rd_after_valid", {31'd0, inst_valid}, 32'd0);
      chk("rd_addr",        imem_addr,           32'h100);
      chk("rd_req",         {31'd0, imem_req},   32'd1);
      slow = 1'b0;
      nxt(); nxt();
      chk("rd_inst_pc", inst_pc, 32'h100);
      chk("rd_inst",    inst,    32'h0050_0193);

      // Misaligned redirect from OUT (overrides stall), then HALT
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
      nxt();
      redirect_valid = 1'b0;
      chk("mis_pulse", {31'd0, misalign},   32'd1);
      chk("mis_pc",    misalign_pc,         32'h102);
      chk("mis_valid", {31'd0, inst_valid}, 32'd0);
      chk("mis_req",   {31'd0, imem_req},   32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      nxt();
      redirect_valid = 1'b0;
      chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
      chk("halt_no_req",   {31'd0, imem_req}, 32'd0);
      nxt();
      chk("halt_still",    {31'd0, imem_req}, 32'd0);
      stall = 1'b0; trap = 1'b1; trap_vec = 32'h80;
      nxt();
      trap = 1'b0;
      chk("trap_req",  {31'd0, imem_req}, 32'd1);
      chk("trap_addr", imem_addr,         32'h80);

      // Priority: all three at once while REQ is granted -> drain, trap_vec wins
      trap = 1'b1; trap_vec = 32'h40; mret = 1'b1; mepc = 32'h60;
      redirect_valid = 1'b1; redirect_pc = 32'h120;
      nxt();
      trap = 1'b0; mret = 1'b0; redirect_valid = 1'b0;
      chk("prio3_drain_req", {31'd0, imem_req}, 32'd0);
      nxt();
      chk("prio3_addr", imem_addr, 32'h40);

      // mret + redirect: mepc wins
      mret = 1'b1; mepc = 32'h60; redirect_valid = 1'b1; redirect_pc = 32'h124;
      nxt();
      mret = 1'b0; redirect_valid = 1'b0;
      nxt();
      chk("prio2_addr", imem_addr,         32'h60);
      chk("prio2_mis",  {31'd0, misalign}, 32'd0);

      // Asynchronous reset mid-operation
      nxt();
      rst_n = 1'b0;
      #1;
      chk("arst_req",     {31'd0, imem_req}, 32'd0);
      chk("arst_addr",    imem_addr,         32'h0);
      chk("arst_inst_pc", inst_pc,           32'h0);
      chk("arst_inst",    inst,              32'h0000_0013);

      // Wrap-around instance
      nxt();
      rst2_n = 1'b1;
      nxt();
      chk("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
      nxt(); nxt();
      chk("wrap_valid0", {31'd0, inst_valid2}, 32'd1);
      chk("wrap_pc0",    inst_pc2,             32'hFFFF_FFF8);
      chk("wrap_inst0",  inst2,                32'hFFAF_FF6B);
      nxt();
      chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
      nxt(); nxt();
      chk("wrap_pc1",   inst_pc2,   32'hFFFF_FFFC);
      chk("wrap_inst1", inst2,      32'hFFAF_FF6F);
      nxt();
      chk("wrap_addr2", imem_addr2, 32'h0000_0000);
      chk("wrap_req2",  {31'd0, imem_req2}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
